// File: rtl/axis_byte_header_insert.sv
// axis_byte_header_insert: prepends a 1..W byte header to each AXI-Stream packet and repacks the payload densely
`timescale 1ns/1ps
module axis_byte_header_insert #(
  parameter int DATA_WD = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    valid_insert,
  output logic                    ready_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [BYTE_CNT_WD-1:0]  hdr_byte_cnt
);
  localparam int CW = BYTE_CNT_WD + 2;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
  state_t state_q, state_d;
  logic [DATA_WD-1:0] res_q, res_d, data_q, data_d, shifted, carry, hmask;
  logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
  logic last_q, last_d, valid_q, valid_d, out_free, in_fire, hdr_fire;
  logic [CW-1:0] h_q, h_d, rem_q, rem_d, k, t;

  function automatic logic [DATA_BYTE_WD-1:0] kmask(input logic [CW-1:0] n);
    logic [DATA_BYTE_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[i] = CW'(i) < n;
    return m;
  endfunction

  function automatic logic [DATA_WD-1:0] bexp(input logic [DATA_BYTE_WD-1:0] m);
    logic [DATA_WD-1:0] e;
    for (int i = 0; i < DATA_BYTE_WD; i++) e[8*i +: 8] = {8{m[i]}};
    return e;
  endfunction

  always_comb begin
    out_free = !valid_q || ready_out;
    ready_in = state_q == STREAM && out_free;
    ready_insert = state_q == IDLE;
    in_fire = valid_in && ready_in;
    hdr_fire = valid_insert && ready_insert;
    k = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) k = k + CW'(keep_in[i]);
    t = h_q + k;
    hmask = ~({DATA_WD{1'b1}} << {h_q, 3'b000});
    shifted = (data_in << {h_q, 3'b000}) | (res_q & hmask);
    // bytes pushed past the top of this beat carry into the next one
    carry = data_in >> {CW'(DATA_BYTE_WD) - h_q, 3'b000};
    state_d = state_q;
    res_d = res_q;
    h_d = h_q;
    rem_d = rem_q;
    data_d = data_q;
    keep_d = keep_q;
    last_d = last_q;
    valid_d = valid_q && !ready_out;
    if (hdr_fire) begin
      res_d = data_insert;
      h_d = CW'(hdr_byte_cnt) + CW'(1);
      state_d = STREAM;
    end
    if (in_fire) begin
      valid_d = 1'b1;
      res_d = carry;
      data_d = shifted;
      keep_d = '1;
      last_d = 1'b0;
      if (last_in) begin
        keep_d = t <= CW'(DATA_BYTE_WD) ? kmask(t) : '1;
        last_d = t <= CW'(DATA_BYTE_WD);
        rem_d = t - CW'(DATA_BYTE_WD);
        state_d = t <= CW'(DATA_BYTE_WD) ? IDLE : FLUSH;
      end
    end
    if (state_q == FLUSH && out_free) begin
      valid_d = 1'b1;
      data_d = res_q;
      keep_d = kmask(rem_q);
      last_d = 1'b1;
      state_d = IDLE;
    end
    data_d = data_d & bexp(keep_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q <= '0;
      h_q <= '0;
      rem_q <= '0;
      data_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q <= res_d;
      h_q <= h_d;
      rem_q <= rem_d;
      data_q <= data_d;
      keep_q <= keep_d;
      last_q <= last_d;
      valid_q <= valid_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out = data_q;
  assign keep_out = keep_q;
  assign last_out = last_q;
endmodule

// File: tb/tb_axis_byte_header_insert.sv
// tb_axis_byte_header_insert: table-driven packets with a scoreboard of expected output beats
`timescale 1ns/1ps
module tb_axis_byte_header_insert;
  logic clk = 0, rst = 1;
  logic valid_in = 0, ready_in, last_in = 0, valid_out, ready_out = 1, last_out;
  logic valid_insert = 0, ready_insert;
  logic [31:0] data_in = 0, data_out, data_insert = 0;
  logic [3:0] keep_in = 0, keep_out;
  logic [1:0] hdr_byte_cnt = 0;
  int checks = 0, errors = 0;
  bit bp = 0;
  logic [36:0] sb[$];
  logic stall_q = 0;
  logic [36:0] prev_q;

  typedef struct {
    logic [1:0] hcnt;
    logic [31:0] hdr;
    int nb;
    logic [1:0][31:0] pd;
    logic [3:0] lk;
    int ne;
    logic [2:0][31:0] ed;
    logic [2:0][3:0] ek;
  } vec_t;
  vec_t v[7];

  axis_byte_header_insert #(.DATA_WD(32)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .valid_insert(valid_insert), .ready_insert(ready_insert), .data_insert(data_insert), .hdr_byte_cnt(hdr_byte_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    ready_out = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic vec_t mk(logic [1:0] hc, logic [31:0] hd, int nb, logic [31:0] p0, logic [31:0] p1,
                              logic [3:0] lk, int ne, logic [31:0] e0, logic [31:0] e1, logic [31:0] e2,
                              logic [3:0] k0, logic [3:0] k1, logic [3:0] k2);
    vec_t r;
    r.hcnt = hc; r.hdr = hd; r.nb = nb; r.pd[0] = p0; r.pd[1] = p1; r.lk = lk; r.ne = ne;
    r.ed[0] = e0; r.ed[1] = e1; r.ed[2] = e2; r.ek[0] = k0; r.ek[1] = k1; r.ek[2] = k2;
    return r;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (stall_q) chk("stall_hold", {27'd0, valid_out, data_out, keep_out, last_out}, {27'd0, 1'b1, prev_q});
      if (valid_out && ready_out) begin
        if (sb.size() == 0) chk("unexpected_beat", {27'd0, data_out, keep_out, last_out}, 64'd0);
        else chk("beat", {27'd0, data_out, keep_out, last_out}, {27'd0, sb.pop_front()});
      end
    end
    stall_q = !rst && valid_out && !ready_out;
    prev_q = {data_out, keep_out, last_out};
  end

  task automatic hdr(input vec_t t, input bit hold);
    int n = 0;
    valid_insert = 1; data_insert = t.hdr; hdr_byte_cnt = t.hcnt;
    for (int e = 0; e < t.ne; e++) sb.push_back({t.ed[e], t.ek[e], e == t.ne - 1});
    while (!ready_insert && n < 100) begin @(negedge clk); n++; end
    if (!ready_insert) chk("hdr_timeout", 0, 1);
    @(posedge clk); #1;
    valid_insert = hold;
  endtask

  task automatic pay(input vec_t t, input bit hold, input vec_t nx);
    int n;
    for (int b = 0; b < t.nb; b++) begin
      valid_in = 1; data_in = t.pd[b]; last_in = b == t.nb - 1;
      keep_in = last_in ? t.lk : 4'($urandom);
      n = 0;
      do begin @(negedge clk); chk("ins_mid", {63'd0, ready_insert}, 0); n++; end
      while (!ready_in && n < 100);
      if (!ready_in) chk("in_timeout", 0, 1);
      @(posedge clk); #1;
    end
    valid_in = 0; last_in = 0;
    if (hold) begin data_insert = nx.hdr; hdr_byte_cnt = nx.hcnt; end
    @(negedge clk);
    chk("rdy_in_after_last", {63'd0, ready_in}, 0);
    chk("rdy_ins_after_last", {63'd0, ready_insert}, {63'd0, !(t.ne > t.nb)});
  endtask

  initial begin
    int n;
    v[0] = mk(2, 32'h00CCBBAA, 2, 32'h44332211, 32'h88776655, 4'hF, 3, 32'h11CCBBAA, 32'h55443322, 32'h00887766, 4'hF, 4'hF, 4'h7);
    v[1] = mk(0, 32'hEEEEEEAA, 2, 32'h44332211, 32'h00000055, 4'h1, 2, 32'h332211AA, 32'h00005544, 0, 4'hF, 4'h3, 0);
    v[2] = mk(3, 32'hDDCCBBAA, 1, 32'h00002211, 0, 4'h3, 2, 32'hDDCCBBAA, 32'h00002211, 0, 4'hF, 4'h3, 0);
    v[3] = mk(1, 32'h0000BBAA, 2, 32'h44332211, 32'h00000055, 4'h1, 2, 32'h2211BBAA, 32'h00554433, 0, 4'hF, 4'h7, 0);
    v[4] = mk(3, 32'h44434241, 2, 32'h04030201, 32'h00000605, 4'h3, 3, 32'h44434241, 32'h04030201, 32'h00000605, 4'hF, 4'hF, 4'h3);
    v[5] = mk(1, 32'h0000BBAA, 2, 32'h44332211, 32'hDEADBEEF, 4'h0, 2, 32'h2211BBAA, 32'h00004433, 0, 4'hF, 4'h3, 0);
    v[6] = mk(3, 32'hDDCCBBAA, 1, 32'h12345678, 0, 4'h0, 1, 32'hDDCCBBAA, 0, 0, 4'hF, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset", {25'd0, valid_out, last_out, keep_out, data_out, ready_in, ready_insert}, 64'd1);
    for (int i = 0; i < 7; i++) begin hdr(v[i], 0); pay(v[i], 0, v[i]); end
    bp = 1;
    for (int r = 0; r < 3; r++) begin hdr(v[0], 0); pay(v[0], 0, v[0]); end
    for (int i = 0; i < 7; i++) begin hdr(v[i], 0); pay(v[i], 0, v[i]); end
    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    bp = 0;
    repeat (3) @(posedge clk);
    #1;
    hdr(v[3], 1); pay(v[3], 1, v[4]);
    hdr(v[4], 0); pay(v[4], 0, v[4]);
    hdr(v[0], 0);
    valid_in = 1; data_in = v[0].pd[0]; keep_in = 4'hF; last_in = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!ready_in && n < 100);
    @(posedge clk); #1;
    valid_in = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    sb.delete();
    @(negedge clk);
    chk("after_rst", {62'd0, valid_out, ready_insert}, 64'd1);
    hdr(v[1], 0); pay(v[1], 0, v[1]);
    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain", 64'(sb.size()), 0);
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
